// File: rtl/piso_pkg.sv
// Shared types for the piso serialiser.
// Holds the two-state FSM encoding that rtl/piso.sv uses.
package piso_pkg;

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

endpackage

// File: rtl/piso.sv
// piso: parallel-in / serial-out transmitter.
// It accepts a DATA_WIDTH-bit word on a one-cycle valid_in strobe while idle.
// It then sends the word one bit per clock, LSB first, with every serial bit qualified by valid_out.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   data_in   parallel word, sampled only on the accepting edge
//   valid_in  load strobe, ignored while busy
//   data_out  serial bit (registered), 0 when idle
//   valid_out high while data_out carries a packet bit (registered)
//   busy      high while a packet is in flight; always equal to valid_out (registered)
module piso
    import piso_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  data_out,
    output logic                  valid_out,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

    state_t                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   shreg_q, shreg_d;
    logic                    data_out_d, valid_out_d, busy_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        data_out_d  = data_out;
        valid_out_d = valid_out;
        busy_d      = busy;

        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    state_d     = StShift;
                    cnt_d       = '0;
                    // Bit 0 goes straight to data_out.
                    // The register keeps the remaining bits, so its LSB is always the next bit.
                    shreg_d     = data_in >> 1;
                    data_out_d  = data_in[0];
                    valid_out_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            StShift: begin
                if (cnt_q == LastCnt) begin
                    state_d     = StIdle;
                    cnt_d       = '0;
                    shreg_d     = '0;
                    data_out_d  = 1'b0;
                    valid_out_d = 1'b0;
                    busy_d      = 1'b0;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
                    shreg_d    = shreg_q >> 1;
                    data_out_d = shreg_q[0];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            data_out  <= 1'b0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shreg_q   <= shreg_d;
            data_out  <= data_out_d;
            valid_out <= valid_out_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_piso.sv
// Self-checking bench for piso.
// A reference model watches the inputs at each rising edge.
// When it sees an accepted word, it queues the word's serial bits.
// A monitor on the falling edge pops the queue and compares it with the DUT outputs.
module tb_piso;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         valid_in = 1'b0;
    logic         data_out, valid_out, busy;

    int checks = 0;
    int passes = 0;

    piso #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a packet occupies the link for W cycles after its accept.
    // New words are taken only once the link is free.
    logic exp_q[$];
    int   remaining = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            remaining = 0;
        end else if (remaining > 0) begin
            remaining = remaining - 1;
        end else if (valid_in === 1'b1) begin
            for (int i = 0; i < int'(W); i++) exp_q.push_back(data_in[i]);
            remaining = W;
        end
    end

    // Monitor
    always @(negedge clk) begin
        check("valid_out", {31'b0, valid_out}, {31'b0, remaining > 0});
        check("busy", {31'b0, busy}, {31'b0, remaining > 0});
        if (valid_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_bit", {31'b0, data_out}, 32'hx);
            end else begin
                check("data_out", {31'b0, data_out}, {31'b0, exp_q.pop_front()});
            end
        end else begin
            check("idle_data_out", {31'b0, data_out}, 32'h0);
        end
    end

    task automatic send(input logic [W-1:0] d);
        @(negedge clk);
        data_in  = d;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("wait_idle_timeout", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        // Reset held across a few edges.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {29'b0, data_out, valid_out, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        send(8'd115);
        wait_idle();
        @(negedge clk);
        send(8'd31);
        wait_idle();
        repeat (2) @(negedge clk);

        // A second strobe arrives mid-packet and must be ignored.
        send(8'hA5);
        repeat (2) @(negedge clk);
        data_in  = 8'hFF;
        valid_in = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // Reset partway through a packet.
        send(8'hFF);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {29'b0, data_out, valid_out, busy}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Strobe held continuously: packets must be separated by idle gaps.
        @(negedge clk);
        data_in  = 8'h01;
        valid_in = 1'b1;
        repeat (30) @(negedge clk);
        valid_in = 1'b0;
        wait_idle();

        // Random traffic with an occasional reset.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            data_in  = W'($urandom);
            valid_in = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        valid_in = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
